regex_match_reporter: RTL and testbench
=======================================

REGEX_MATCH_REPORTER -- requirements
Module: regex_match_reporter

Interface
REQ-001 Parameter DEPTH, default 8: match FIFO depth in entries, power of two, minimum 2.
REQ-002 Parameter OFF_W, default 32: width of the character offset counter and reported offsets.
REQ-003 clk  input  1  clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 char_vld  input  1  same signal that drives the matcher's char-valid; one character consumed per high cycle.
REQ-006 accept_in  input  1  matcher accept output for the current cycle's character.
REQ-007 stream_start  input  1  driven with the matcher's state-load strobe; marks start of a new stream.
REQ-008 clear_ovf  input  1  single-cycle pulse clearing overflow and drop_cnt.
REQ-009 match_rdy  input  1  consumer ready for the FIFO head.
REQ-010 match_vld  output  1  FIFO non-empty.
REQ-011 match_off  output  OFF_W  offset of the character that completed the oldest unread match.
REQ-012 fifo_cnt  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-013 overflow  output  1  sticky: at least one match dropped since last clear.
REQ-014 drop_cnt  output  8  matches dropped since last clear, saturating.

Function
REQ-015 Offset counter: 0-based count of characters consumed since the last stream_start or reset.
REQ-016 stream_start high: counter loads 0; char_vld and accept_in ignored that cycle, no push.
REQ-017 stream_start low, char_vld high: counter increments by 1, wrapping modulo 2^OFF_W.
REQ-018 Push request = !stream_start & char_vld & accept_in; pushed value = counter value before increment.
REQ-019 accept_in with char_vld low: ignored, no push, counter unchanged.
REQ-020 Pop = match_vld & match_rdy; head advances at the clock edge.
REQ-021 Latency: push at edge N -> match_vld high and match_off valid from after edge N (visible cycle N+1) when FIFO was empty.
REQ-022 match_off, match_vld, fifo_cnt driven from registers/storage; no combinational path from accept_in or char_vld.
REQ-023 match_off holds stable while match_vld high and match_rdy low.
REQ-024 Push and pop same cycle, FIFO non-empty: both performed, fifo_cnt unchanged, no drop even if full.
REQ-025 Push and pop same cycle, FIFO empty: pop ignored (match_vld low), push performed, fifo_cnt becomes 1.
REQ-026 Push when full with no pop: entry dropped, FIFO contents unchanged, overflow set, drop_cnt +1 saturating at 255.
REQ-027 Pop when empty: no effect.
REQ-028 Read/write pointers wrap modulo DEPTH; fifo_cnt never exceeds DEPTH.
REQ-029 clear_ovf alone: overflow <= 0, drop_cnt <= 0 next edge.
REQ-030 clear_ovf coincident with a drop: overflow <= 1, drop_cnt <= 1.
REQ-031 stream_start does not flush the FIFO; pending entries from the previous stream remain readable in order.

Reset
REQ-032 rst_n low at a clock edge: counter 0, FIFO pointers 0, fifo_cnt 0, match_vld 0, overflow 0, drop_cnt 0; all other inputs ignored that cycle.
REQ-033 match_off after reset is don't-care while match_vld is 0.
REQ-034 Reset mid-operation discards all queued matches; first post-reset push reports offset per the counter restarted at 0.

Verification
REQ-035 Reset, stream_start, 6 chars with accept_in high on chars 2 and 5 -> two entries, match_off 2 then 5, fifo_cnt peaks at 2.
REQ-036 match_rdy held low, DEPTH+3 accepting chars -> fifo_cnt=DEPTH, overflow=1, drop_cnt=3, stored offsets 0..DEPTH-1; then clear_ovf -> overflow=0, drop_cnt=0.
REQ-037 FIFO full, match_rdy high and accepting char same cycle -> no drop, fifo_cnt stays DEPTH, new offset appended at tail.
REQ-038 stream_start coincident with char_vld & accept_in -> no push, counter 0; next accepting char reports offset 0.
REQ-039 OFF_W=4, 17 chars with accept on last -> reported offset 0 (wrap).
REQ-040 3 entries queued, rst_n low one cycle -> match_vld 0, fifo_cnt 0, next accepting char after stream_start reports 0.

Source files
------------

// File: rtl/regex_match_reporter.sv
`default_nettype none
// ============================================================================
// Module   : regex_match_reporter
// Brief    : Counts characters fed to a regex matcher and queues the offset
//            of every character on which the matcher accepted. Matches that
//            arrive while the queue is full are dropped and counted.
// Revision : 1.0 - initial release
// ============================================================================
module regex_match_reporter #(
  parameter int DEPTH = 8,   // queue depth, power of two, at least 2
  parameter int OFF_W = 32   // width of the character offset counter
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     char_vld,
  input  logic                     accept_in,
  input  logic                     stream_start,
  input  logic                     clear_ovf,
  input  logic                     match_rdy,
  output logic                     match_vld,
  output logic [OFF_W-1:0]         match_off,
  output logic [$clog2(DEPTH):0]   fifo_cnt,
  output logic                     overflow,
  output logic [7:0]               drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]      C_FULL    = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]    C_PTR_ONE = AW'(1);
  localparam logic [AW:0]      C_CNT_ONE = (AW+1)'(1);
  localparam logic [OFF_W-1:0] C_OFF_ONE = OFF_W'(1);
  localparam logic [7:0]       C_DROP_MAX = 8'hFF;

  logic [OFF_W-1:0] r_off;
  logic [OFF_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_cnt;
  logic             r_overflow;
  logic [7:0]       r_drop;

  logic w_push_req;
  logic w_pop;
  logic w_full;
  logic w_push;
  logic w_drop;

  // A character loaded on the same cycle as stream_start belongs to nothing,
  // so it can never produce a match. A pop only happens when there is a head.
  // When full, a simultaneous pop frees the slot the push needs.
  always_comb begin
    w_push_req = !stream_start && char_vld && accept_in;
    w_pop      = (r_cnt != '0) && match_rdy;
    w_full     = (r_cnt == C_FULL);
    w_push     = w_push_req && (!w_full || w_pop);
    w_drop     = w_push_req && w_full && !w_pop;
  end

  // Outputs come straight from registered state and queue storage.
  assign match_vld = (r_cnt != '0);
  assign match_off = r_mem[r_rptr];
  assign fifo_cnt  = r_cnt;
  assign overflow  = r_overflow;
  assign drop_cnt  = r_drop;

  // Character offset counter: restarts on a new stream, wraps naturally.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_off <= '0;
    end else if (stream_start) begin
      r_off <= '0;
    end else if (char_vld) begin
      r_off <= r_off + C_OFF_ONE;
    end
  end

  // Queue storage; contents need no reset since they are only read when valid.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_mem[r_wptr] <= r_off;
    end
  end

  // Queue pointers and occupancy; pointers wrap because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + C_PTR_ONE;
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + C_CNT_ONE;
      end else if (w_pop && !w_push) begin
        r_cnt <= r_cnt - C_CNT_ONE;
      end
    end
  end

  // Drop bookkeeping; a drop on the clearing cycle is kept rather than lost.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
      r_drop     <= '0;
    end else if (clear_ovf) begin
      r_overflow <= w_drop;
      r_drop     <= w_drop ? 8'd1 : 8'd0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      r_drop     <= (r_drop == C_DROP_MAX) ? C_DROP_MAX : r_drop + 8'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regex_match_reporter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regex_match_reporter
// Brief    : Directed and random stimulus for regex_match_reporter, checked
//            against a queue-based reference model. A second instance with a
//            4-bit offset exercises counter wrap.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regex_match_reporter;

  localparam int DEPTH = 8;
  localparam int OFF_W = 32;
  localparam int AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst_n, char_vld, accept_in, stream_start, clear_ovf, match_rdy;

  logic             match_vld;
  logic [OFF_W-1:0] match_off;
  logic [AW:0]      fifo_cnt;
  logic             overflow;
  logic [7:0]       drop_cnt;

  logic             s_match_vld;
  logic [3:0]       s_match_off;
  logic [AW:0]      s_fifo_cnt;
  logic             s_overflow;
  logic [7:0]       s_drop_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] mq[$];
  logic [31:0] m_cnt = 0;
  logic        m_ov  = 0;
  int          m_dc  = 0;

  always #5 clk = ~clk;

  regex_match_reporter #(.DEPTH(DEPTH), .OFF_W(OFF_W)) dut (
    .clk(clk), .rst_n(rst_n), .char_vld(char_vld), .accept_in(accept_in),
    .stream_start(stream_start), .clear_ovf(clear_ovf), .match_rdy(match_rdy),
    .match_vld(match_vld), .match_off(match_off), .fifo_cnt(fifo_cnt),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  regex_match_reporter #(.DEPTH(DEPTH), .OFF_W(4)) dut_small (
    .clk(clk), .rst_n(rst_n), .char_vld(char_vld), .accept_in(accept_in),
    .stream_start(stream_start), .clear_ovf(clear_ovf), .match_rdy(match_rdy),
    .match_vld(s_match_vld), .match_off(s_match_off), .fifo_cnt(s_fifo_cnt),
    .overflow(s_overflow), .drop_cnt(s_drop_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Spec-level model of one clock edge with the currently driven inputs.
  task automatic model_edge();
    bit push, pop, drop;
    if (!rst_n) begin
      mq.delete();
      m_cnt = 0;
      m_ov  = 0;
      m_dc  = 0;
    end else begin
      push = !stream_start && char_vld && accept_in;
      pop  = (mq.size() != 0) && match_rdy;
      drop = push && !pop && (mq.size() == DEPTH);
      if (pop) void'(mq.pop_front());
      if (push && !drop) mq.push_back(m_cnt);
      if (stream_start) m_cnt = 0;
      else if (char_vld) m_cnt = m_cnt + 1;
      if (clear_ovf) begin
        m_ov = drop;
        m_dc = drop ? 1 : 0;
      end else if (drop) begin
        m_ov = 1'b1;
        if (m_dc < 255) m_dc++;
      end
    end
  endtask

  task automatic check_all();
    logic [31:0] head;
    chk("vld", 64'(match_vld), 64'(mq.size() != 0));
    chk("cnt", 64'(fifo_cnt), 64'(mq.size()));
    chk("ovf", 64'(overflow), 64'(m_ov));
    chk("drop", 64'(drop_cnt), 64'(m_dc));
    chk("s_vld", 64'(s_match_vld), 64'(mq.size() != 0));
    chk("s_cnt", 64'(s_fifo_cnt), 64'(mq.size()));
    if (mq.size() != 0) begin
      head = mq[0];
      chk("off", 64'(match_off), 64'(head));
      chk("s_off", 64'(s_match_off), 64'(head[3:0]));
    end
  endtask

  task automatic step(input logic r, input logic sv, input logic cv,
                      input logic acc, input logic clr, input logic rdy);
    rst_n = r; stream_start = sv; char_vld = cv;
    accept_in = acc; clear_ovf = clr; match_rdy = rdy;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drain();
    for (int i = 0; i < DEPTH + 1; i++) step(1, 0, 0, 0, 0, 1);
  endtask

  initial begin
    // Reset state
    step(0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 1, 1, 1);
    chk("rst_vld", 64'(match_vld), 64'(0));
    chk("rst_cnt", 64'(fifo_cnt), 64'(0));
    chk("rst_ovf", 64'(overflow), 64'(0));
    chk("rst_drop", 64'(drop_cnt), 64'(0));

    // Six characters, accepts on offsets 2 and 5
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 1, (i == 2 || i == 5), 0, 0);
    chk("two_cnt", 64'(fifo_cnt), 64'(2));
    chk("two_off0", 64'(match_off), 64'(2));
    step(1, 0, 0, 0, 0, 1);
    chk("two_off1", 64'(match_off), 64'(5));
    step(1, 0, 0, 0, 0, 1);
    chk("two_empty", 64'(match_vld), 64'(0));

    // Overflow by three, then clear
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH + 3; i++) step(1, 0, 1, 1, 0, 0);
    chk("ovf_cnt", 64'(fifo_cnt), 64'(DEPTH));
    chk("ovf_flag", 64'(overflow), 64'(1));
    chk("ovf_drop", 64'(drop_cnt), 64'(3));
    chk("ovf_head", 64'(match_off), 64'(0));
    step(1, 0, 0, 0, 1, 0);
    chk("clr_flag", 64'(overflow), 64'(0));
    chk("clr_drop", 64'(drop_cnt), 64'(0));

    // Full, pop and push together: no drop, new tail is offset DEPTH+3
    step(1, 0, 1, 1, 0, 1);
    chk("full_pp_cnt", 64'(fifo_cnt), 64'(DEPTH));
    chk("full_pp_drop", 64'(drop_cnt), 64'(0));
    chk("full_pp_head", 64'(match_off), 64'(1));
    drain();

    // stream_start masks a coincident accept
    step(1, 1, 1, 1, 0, 0);
    chk("ss_novld", 64'(match_vld), 64'(0));
    step(1, 0, 1, 1, 0, 0);
    chk("ss_off", 64'(match_off), 64'(0));
    drain();

    // Push and pop together into an empty queue
    step(1, 0, 1, 1, 0, 1);
    chk("empty_pp_cnt", 64'(fifo_cnt), 64'(1));
    drain();

    // 4-bit offset wrap: 17th character reports 0
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < 17; i++) step(1, 0, 1, (i == 16), 0, 0);
    chk("wrap_small", 64'(s_match_off), 64'(0));
    chk("wrap_big", 64'(match_off), 64'(16));
    drain();

    // Saturation of drop_cnt, then clear coincident with a drop
    step(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH + 300; i++) step(1, 0, 1, 1, 0, 0);
    chk("sat_drop", 64'(drop_cnt), 64'(255));
    step(1, 0, 1, 1, 1, 0);
    chk("clrdrop_flag", 64'(overflow), 64'(1));
    chk("clrdrop_drop", 64'(drop_cnt), 64'(1));
    step(1, 0, 0, 0, 1, 0);
    chk("clr2_drop", 64'(drop_cnt), 64'(0));
    drain();

    // Reset discards queued matches
    for (int i = 0; i < 3; i++) step(1, 0, 1, 1, 0, 0);
    chk("pre_rst_cnt", 64'(fifo_cnt), 64'(3));
    step(0, 0, 1, 1, 0, 1);
    chk("mid_rst_vld", 64'(match_vld), 64'(0));
    chk("mid_rst_cnt", 64'(fifo_cnt), 64'(0));
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    chk("post_rst_off", 64'(match_off), 64'(0));
    drain();

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 199) != 0),
           ($urandom_range(0, 15) == 0),
           ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 1) == 0),
           ($urandom_range(0, 31) == 0),
           (i % 1000 < 500) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 1) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
